ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 8, maximum pixels per frame the block indexes.
REQ-002 Parameter SYSTEM_CLOCK, default 50000000, clk_i frequency in Hz; all timing constants derive from it.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous and active-high.
REQ-005 din_i  in  1  asynchronous serial line from a WS2812/SK6812 chain driver.
REQ-006 pixel_valid_o  out  1  one-cycle pulse; green_o/red_o/blue_o/pixel_index_o valid this cycle.
REQ-007 green_o, red_o, blue_o  out  8 each  decoded colour bytes, MSB first on the wire, order G,R,B.
REQ-008 pixel_index_o  out  $clog2(NUM_LEDS)  index of the pixel being reported, 0 = first after reset gap.
REQ-009 frame_done_o  out  1  one-cycle pulse on reset-gap detection when at least one bit was received since the last gap.
REQ-010 error_o  out  1  one-cycle pulse on a malformed bit or a partial pixel.
REQ-011 busy_o  out  1  high from the first rising edge after a gap until the next gap is detected.
REQ-012 dout_o  out  1  regenerated forward output (see Configuration).

Function
REQ-013 din_i SHALL pass through a 2-flop synchroniser; edge detection uses synchronised samples only, adding 2 cycles of latency.
REQ-014 Constants: CYCLE_COUNT = SYSTEM_CLOCK/800000 (62); BIT_THRESH = 0.375*CYCLE_COUNT (23); MIN_HIGH = CYCLE_COUNT/8 (7); MAX_BIT = 2*CYCLE_COUNT (124); RESET_DETECT = 40*CYCLE_COUNT (2480).
REQ-015 FSM states: GAP (wait for line low RESET_DETECT cycles), IDLE (armed, line low), HIGH (counting high width), LOW (counting low width).
REQ-016 After reset_i the FSM SHALL be in GAP; first rising edges before RESET_DETECT low cycles elapse are ignored.
REQ-017 IDLE -> HIGH on synchronised rising edge; width counter cleared to 1.
REQ-018 HIGH -> LOW on falling edge: width < MIN_HIGH gives error_o pulse and pixel discard; else bit = (width > BIT_THRESH), shifted into a 24-bit register MSB first.
REQ-019 HIGH with width reaching MAX_BIT SHALL pulse error_o, discard the pixel, enter GAP.
REQ-020 LOW -> HIGH on rising edge; LOW counting to RESET_DETECT SHALL go to IDLE and pulse frame_done_o.
REQ-021 On the 24th accepted bit, pixel_valid_o SHALL pulse the following cycle with G=bits[23:16], R=[15:8], B=[7:0]; bit count clears; pixel_index_o then increments.
REQ-022 Pixels beyond NUM_LEDS-1: pixel_index_o SHALL saturate at NUM_LEDS-1 and pixel_valid_o still pulses.
REQ-023 Gap detected with bit count not 0 and not 24: error_o and frame_done_o pulse in the same cycle, partial bits discarded.
REQ-024 On gap: pixel_index_o and bit count clear to 0; busy_o drops the same cycle frame_done_o pulses.
REQ-025 Width counters SHALL saturate, never wrap.

Reset
REQ-026 reset_i SHALL force: state GAP, synchroniser 0, counters 0, pixel_valid_o/frame_done_o/error_o/busy_o/dout_o 0, colour outputs 0x00, pixel_index_o 0.
REQ-027 reset_i mid-frame SHALL discard in-progress bits with no error_o pulse.

Configuration
REQ-028 Macro WS2812_RX_FORWARD_EN defined: block behaves as a chain element; it consumes the first 24 bits after a gap and copies the synchronised line to dout_o for all later bits until the next gap; dout_o low during the first pixel; pixel_valid_o fires only for pixel 0.
REQ-029 Macro undefined: dout_o tied 0; all pixels reported per REQ-021.

Structure
REQ-030 Shared package ws2812_pkg SHALL hold CYCLE_COUNT, threshold fractions, and the G/R/B byte-order constants shared with the transmitter.
REQ-031 Sub-module ws2812_pulse_meter (synchroniser, edge detect, saturating width counter) SHALL be instantiated once.

Verification
REQ-032 Gap, then pixel G=0xA5 R=0x3C B=0xFF with SK6812 timing (H0=15, H1=31 cycles, 62-cycle bits) -> pixel_valid_o with 0xA5/0x3C/0xFF, index 0.
REQ-033 3 pixels then 2480-cycle low -> indices 0,1,2, then frame_done_o, busy_o 0, next frame index 0.
REQ-034 5-cycle high pulse mid-pixel -> error_o pulse, pixel discarded, no pixel_valid_o.
REQ-035 12 bits then gap -> error_o and frame_done_o same cycle, no pixel_valid_o.
REQ-036 NUM_LEDS=4, 6 pixels -> indices 0,1,2,3,3,3.
REQ-037 With WS2812_RX_FORWARD_EN, 2 pixels -> pixel_valid_o only for index 0, dout_o carries pixel 1 delayed 2 cycles.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812/SK6812 definitions: bit-timing fractions, colour byte order
// and the receiver state encoding.
package ws2812_pkg;

  localparam int BIT_RATE_HZ    = 800000;
  // The 0/1 decision point sits at 3/8 of a bit period.
  localparam int THRESH_NUM     = 3;
  localparam int THRESH_DEN     = 8;
  localparam int MIN_HIGH_DEN   = 8;
  localparam int MAX_BIT_MULT   = 2;
  localparam int RESET_MULT     = 40;
  localparam int BITS_PER_PIXEL = 24;

  // Byte positions inside a 24-bit pixel word; the wire order is G, R, B.
  localparam int GREEN_BYTE = 2;
  localparam int RED_BYTE   = 1;
  localparam int BLUE_BYTE  = 0;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } rx_state_t;

  function automatic int cycle_count(input int clock_hz);
    return clock_hz / BIT_RATE_HZ;
  endfunction

  function automatic logic [7:0] colour_byte(input logic [23:0] word, input int pos);
    return word[pos*8 +: 8];
  endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronises the serial line, flags its edges and measures how many cycles
// the synchronised level has been stable since the last edge.
module ws2812_pulse_meter #(
  parameter int WIDTH_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic [WIDTH_W-1:0] width
);

  logic [1:0] sync;
  logic       prev;

  assign level = sync[1];
  assign rise  = sync[1] & ~prev;
  assign fall  = ~sync[1] & prev;

  // Width restarts at 1 on every edge and sticks at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= '0;
      prev  <= 1'b0;
      width <= '0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
      if (rise || fall) begin
        width <= WIDTH_W'(1);
      end else if (width != '1) begin
        width <= width + WIDTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812/SK6812 serial receiver: decodes G,R,B pixels and frame gaps.
// Define WS2812_RX_FORWARD_EN to keep only pixel 0 and regenerate the rest on dout_o.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter  int NUM_LEDS     = 8,
  parameter  int SYSTEM_CLOCK = 50000000,
  localparam int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             din_i,
  output logic             pixel_valid_o,
  output logic [7:0]       green_o,
  output logic [7:0]       red_o,
  output logic [7:0]       blue_o,
  output logic [IDX_W-1:0] pixel_index_o,
  output logic             frame_done_o,
  output logic             error_o,
  output logic             busy_o,
  output logic             dout_o
);

  localparam int CYCLE_COUNT  = cycle_count(SYSTEM_CLOCK);
  localparam int BIT_THRESH   = CYCLE_COUNT * THRESH_NUM / THRESH_DEN;
  localparam int MIN_HIGH     = CYCLE_COUNT / MIN_HIGH_DEN;
  localparam int MAX_BIT      = MAX_BIT_MULT * CYCLE_COUNT;
  localparam int RESET_DETECT = RESET_MULT * CYCLE_COUNT;
  localparam int WIDTH_W      = $clog2(RESET_DETECT + 1);

  localparam logic [WIDTH_W-1:0] THRESH_W = WIDTH_W'(BIT_THRESH);
  localparam logic [WIDTH_W-1:0] MIN_W    = WIDTH_W'(MIN_HIGH);
  localparam logic [WIDTH_W-1:0] MAX_W    = WIDTH_W'(MAX_BIT);
  localparam logic [WIDTH_W-1:0] RESET_W  = WIDTH_W'(RESET_DETECT);
  localparam logic [IDX_W-1:0]   IDX_MAX  = IDX_W'(NUM_LEDS - 1);
  localparam logic [4:0]         LAST_BIT = 5'(BITS_PER_PIXEL - 1);

  rx_state_t          state, next_state;
  logic               level, rise, fall;
  logic [WIDTH_W-1:0] width;
  logic               take_bit, short_bit, overrun, gap_hit;
  logic [22:0]        shift;
  logic [4:0]         bit_cnt;
  logic [IDX_W-1:0]   idx;
  logic               seen, busy, fwd;
  logic               bit_val;
  logic [23:0]        word;

  ws2812_pulse_meter #(.WIDTH_W(WIDTH_W)) u_meter (
    .clock (clk_i),
    .reset (reset_i),
    .din   (din_i),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .width (width)
  );

  assign bit_val       = width > THRESH_W;
  assign word          = {shift, bit_val};
  assign pixel_index_o = idx;
  assign busy_o        = busy;

`ifdef WS2812_RX_FORWARD_EN
  assign dout_o = level & fwd;
`else
  assign dout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_GAP;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    take_bit   = 1'b0;
    short_bit  = 1'b0;
    overrun    = 1'b0;
    gap_hit    = 1'b0;
    case (state)
      ST_GAP: begin
        if (!level && width >= RESET_W) begin
          next_state = ST_IDLE;
          gap_hit    = 1'b1;
        end
      end
      ST_IDLE: begin
        if (rise) next_state = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          next_state = ST_LOW;
          short_bit  = width < MIN_W;
          take_bit   = width >= MIN_W;
        end else if (width >= MAX_W) begin
          next_state = ST_GAP;
          overrun    = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          next_state = ST_HIGH;
        end else if (width >= RESET_W) begin
          next_state = ST_IDLE;
          gap_hit    = 1'b1;
        end
      end
      default: next_state = ST_GAP;
    endcase
  end

  // A gap wins over everything else: it reports the frame and clears all
  // per-frame bookkeeping, flagging a half-received pixel as an error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift         <= '0;
      bit_cnt       <= '0;
      idx           <= '0;
      seen          <= 1'b0;
      busy          <= 1'b0;
      fwd           <= 1'b0;
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      error_o       <= 1'b0;
      green_o       <= '0;
      red_o         <= '0;
      blue_o        <= '0;
    end else begin
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      error_o       <= 1'b0;
      if (state == ST_IDLE && rise) busy <= 1'b1;
      if (pixel_valid_o && idx != IDX_MAX) idx <= idx + IDX_W'(1);
      if (take_bit && !fwd) begin
        seen <= 1'b1;
        if (bit_cnt == LAST_BIT) begin
          pixel_valid_o <= 1'b1;
          green_o       <= colour_byte(word, GREEN_BYTE);
          red_o         <= colour_byte(word, RED_BYTE);
          blue_o        <= colour_byte(word, BLUE_BYTE);
          bit_cnt       <= '0;
`ifdef WS2812_RX_FORWARD_EN
          fwd           <= 1'b1;
`endif
        end else begin
          shift   <= word[22:0];
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (short_bit || overrun) begin
        error_o <= 1'b1;
        bit_cnt <= '0;
      end
      if (gap_hit) begin
        frame_done_o <= seen;
        error_o      <= bit_cnt != '0;
        bit_cnt      <= '0;
        idx          <= '0;
        busy         <= 1'b0;
        seen         <= 1'b0;
        fwd          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: a pixel/frame-level model predicts
// decoded pixels, frame ends and error pulses from the transmitted symbols.
module tb_ws2812_rx;

  localparam int NUM_LEDS = 4;
  localparam int IDX_W    = 2;
  localparam int T0H      = 15;
  localparam int T0L      = 47;
  localparam int T1H      = 31;
  localparam int T1L      = 31;
  localparam int GAP_LEN  = 2600;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             din   = 1'b0;
  logic             pixel_valid, frame_done, err_pulse, busy, dout;
  logic [7:0]       green, red, blue;
  logic [IDX_W-1:0] pixel_index;

  typedef struct packed {
    logic [7:0]       g;
    logic [7:0]       r;
    logic [7:0]       b;
    logic [IDX_W-1:0] idx;
  } pix_t;

  pix_t exp_pix[$];
  bit   exp_frame[$];
  int   exp_err       = 0;
  bit   armed         = 0;
  bit   any_bit       = 0;
  bit   fwd_window    = 0;
  int   bits_in_pixel = 0;
  int   frame_pix     = 0;

  int   errors = 0;
  int   checks = 0;
  int   n_pix = 0, n_frame = 0, n_err = 0;
  int   idx_log[$];
  logic [7:0] last_g = '0, last_r = '0, last_b = '0;
  int   last_idx = -1;
  logic d1 = 1'b0, d2 = 1'b0;
  pix_t got;
  bit   frame_err;
  int   base_pix;
  int   seq3[3] = '{0, 1, 2};
  int   seq6[6] = '{0, 1, 2, 3, 3, 3};

  always #10 clk = ~clk;

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(50000000)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .din_i         (din),
    .pixel_valid_o (pixel_valid),
    .green_o       (green),
    .red_o         (red),
    .blue_o        (blue),
    .pixel_index_o (pixel_index),
    .frame_done_o  (frame_done),
    .error_o       (err_pulse),
    .busy_o        (busy),
    .dout_o        (dout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveLevel(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 din = v;
    end
  endtask

  task automatic sendBit(input logic b);
    if (armed) begin
      any_bit = 1;
`ifdef WS2812_RX_FORWARD_EN
      fwd_window = frame_pix >= 1;
`endif
      bits_in_pixel++;
      if (bits_in_pixel == 24) begin
        bits_in_pixel = 0;
        frame_pix++;
      end
    end
    if (b) begin
      driveLevel(1'b1, T1H);
      driveLevel(1'b0, T1L);
    end else begin
      driveLevel(1'b1, T0H);
      driveLevel(1'b0, T0L);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    logic [23:0] w;
    pix_t p;
    w = {g, r, b};
    for (int i = 23; i >= 0; i--) begin
      if (armed && bits_in_pixel == 23) begin
        p.g = g;
        p.r = r;
        p.b = b;
        p.idx = IDX_W'((frame_pix < NUM_LEDS) ? frame_pix : NUM_LEDS - 1);
`ifdef WS2812_RX_FORWARD_EN
        if (frame_pix == 0) exp_pix.push_back(p);
`else
        exp_pix.push_back(p);
`endif
      end
      sendBit(w[i]);
    end
  endtask

  task automatic sendBits(input int n, input logic [23:0] pat);
    for (int i = n - 1; i >= 0; i--) sendBit(pat[i]);
  endtask

  task automatic shortPulse();
    if (armed) begin
      exp_err++;
      bits_in_pixel = 0;
    end
    driveLevel(1'b1, 5);
    driveLevel(1'b0, 57);
  endtask

  task automatic longHigh();
    if (armed) begin
      exp_err++;
      bits_in_pixel = 0;
      armed = 0;
    end
    driveLevel(1'b1, 130);
    driveLevel(1'b0, 10);
  endtask

  task automatic sendGap();
    if (any_bit) exp_frame.push_back(bits_in_pixel != 0);
    any_bit       = 0;
    bits_in_pixel = 0;
    frame_pix     = 0;
    armed         = 1;
    fwd_window    = 0;
    driveLevel(1'b0, GAP_LEN);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset         = 1'b1;
    din           = 1'b0;
    armed         = 0;
    any_bit       = 0;
    bits_in_pixel = 0;
    frame_pix     = 0;
    fwd_window    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", pixel_valid, 0);
    checkOutput("rst_frame", frame_done, 0);
    checkOutput("rst_error", err_pulse, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_green", green, 0);
    checkOutput("rst_red", red, 0);
    checkOutput("rst_blue", blue, 0);
    checkOutput("rst_index", pixel_index, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(posedge clk) begin
    d1 <= din;
    d2 <= d1;
  end

  // Event-level compare against the model queues on every active cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("dout", dout, fwd_window ? d2 : 1'b0);
      if (pixel_valid) begin
        n_pix++;
        idx_log.push_back(int'(pixel_index));
        last_g   = green;
        last_r   = red;
        last_b   = blue;
        last_idx = int'(pixel_index);
        if (exp_pix.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pixel_unexpected: got=%0h_%0h_%0h idx=%0d want=none", green, red, blue, pixel_index);
        end else begin
          got = exp_pix.pop_front();
          checkOutput("green", green, got.g);
          checkOutput("red", red, got.r);
          checkOutput("blue", blue, got.b);
          checkOutput("index", pixel_index, got.idx);
          checkOutput("busy_in_frame", busy, 1);
        end
      end
      if (frame_done) begin
        n_frame++;
        if (exp_frame.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame_unexpected: got=1 want=0 at %0t", $time);
        end else begin
          frame_err = exp_frame.pop_front();
          checkOutput("frame_error", err_pulse, frame_err);
          checkOutput("busy_at_gap", busy, 0);
        end
      end else if (err_pulse) begin
        n_err++;
        checks++;
        if (exp_err == 0) begin
          errors++;
          $display("[TB] FAIL error_unexpected: got=1 want=0 at %0t", $time);
        end else begin
          exp_err--;
        end
      end
    end
  end

  initial begin
    $display("[TB] start");
    doReset();

    applyStimulus(8'h11, 8'h22, 8'h33);
    sendGap();
    checkOutput("ignored_pixels", n_pix, 0);
    checkOutput("ignored_frames", n_frame, 0);

    applyStimulus(8'hA5, 8'h3C, 8'hFF);
    sendGap();
    checkOutput("lit_green", last_g, 8'hA5);
    checkOutput("lit_red", last_r, 8'h3C);
    checkOutput("lit_blue", last_b, 8'hFF);
    checkOutput("lit_index", last_idx, 0);
    checkOutput("lit_frames", n_frame, 1);

    idx_log.delete();
    applyStimulus(8'h01, 8'h80, 8'h7E);
    applyStimulus(8'hFF, 8'h00, 8'h55);
    applyStimulus(8'h00, 8'hC3, 8'h01);
    sendGap();
`ifndef WS2812_RX_FORWARD_EN
    checkOutput("seq3_len", idx_log.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("seq3_idx", (i < idx_log.size()) ? idx_log[i] : -1, seq3[i]);
`endif
    idx_log.delete();
    applyStimulus(8'h5A, 8'h5A, 8'h5A);
    sendGap();
    checkOutput("next_frame_idx", (idx_log.size() > 0) ? idx_log[0] : -1, 0);

    base_pix = n_pix;
    sendBits(10, 24'h0002D5);
    shortPulse();
    sendGap();
    checkOutput("short_no_pixel", n_pix - base_pix, 0);

    base_pix = n_pix;
    sendBits(12, 24'h000A3C);
    sendGap();
    checkOutput("partial_no_pixel", n_pix - base_pix, 0);

    idx_log.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'(i * 17), 8'(255 - i), 8'(i * 3 + 1));
    sendGap();
`ifndef WS2812_RX_FORWARD_EN
    checkOutput("seq6_len", idx_log.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput("seq6_idx", (i < idx_log.size()) ? idx_log[i] : -1, seq6[i]);
`endif

    longHigh();
    sendGap();

    sendBits(12, 24'h000FF0);
    doReset();
    sendGap();
    repeat (20) @(posedge clk);

    checkOutput("pending_pixels", exp_pix.size(), 0);
    checkOutput("pending_frames", exp_frame.size(), 0);
    checkOutput("pending_errors", exp_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
